// File: rtl/param_bus_reg.sv
// Registered priority bus: the lowest-index enabled source is latched onto
// bus_out; adds hold/idle modes, conflict pulse and saturating counter.
// Ports: clock, clear (async high); src_en/src_data sources; hold_en;
//   cnt_clr; bus_out/bus_valid/bus_sel; conflict/conflict_cnt; state.
module param_bus_reg #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 24,
  parameter int CNT_W = 8,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0,
  localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [N_SRC-1:0]       src_en,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic                   hold_en,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       bus_out,
  output logic                   bus_valid,
  output logic [SEL_W-1:0]       bus_sel,
  output logic                   conflict,
  output logic [CNT_W-1:0]       conflict_cnt,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    HOLD  = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             conf_q, conf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             any_en;
  logic             multi;
  logic [SEL_W-1:0] win_sel;
  logic [WIDTH-1:0] win_data;

  assign any_en = |src_en;
  // x & (x-1) clears the lowest set bit; nonzero means two or more set.
  assign multi  = |(src_en & (src_en - N_SRC'(1)));

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    win_sel  = '0;
    win_data = src_data[WIDTH-1:0];
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_en[i]) begin
        win_sel  = SEL_W'(i);
        win_data = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    conf_d  = multi;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (any_en) state_d = DRIVE;
        else        state_d = IDLE;
      end
      DRIVE, HOLD: begin
        if (any_en)       state_d = DRIVE;
        else if (hold_en) state_d = HOLD;
        else              state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      DRIVE: begin
        out_d   = win_data;
        sel_d   = win_sel;
        valid_d = 1'b1;
      end
      HOLD: begin
        out_d = out_q;
        sel_d = sel_q;
      end
      default: begin
        out_d = IDLE_VAL;
        sel_d = '0;
      end
    endcase

    if (cnt_clr)
      cnt_d = '0;
    else if (multi && cnt_q != CNT_MAX)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      out_q   <= IDLE_VAL;
      sel_q   <= '0;
      valid_q <= 1'b0;
      conf_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      conf_q  <= conf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_out      = out_q;
  assign bus_valid    = valid_q;
  assign bus_sel      = sel_q;
  assign conflict     = conf_q;
  assign conflict_cnt = cnt_q;
  assign state        = state_q;

endmodule

// File: tb/tb_param_bus_reg.sv
// Scoreboard bench for param_bus_reg: default build plus a small
// WIDTH=8/N_SRC=3/CNT_W=2 build with a nonzero idle value.
module tb_param_bus_reg;

  typedef struct {
    logic [31:0] out;
    logic        valid;
    logic [4:0]  sel;
    logic        conf;
    logic [7:0]  cnt;
    logic [1:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  // default build
  logic [23:0]     en0;
  logic [24*32-1:0] dat0;
  logic            hold0, cclr0;
  logic [31:0]     out0;
  logic            val0, conf0;
  logic [4:0]      sel0;
  logic [7:0]      cnt0;
  logic [1:0]      st0;

  // small build
  logic [2:0]  en1;
  logic [23:0] dat1;
  logic        hold1, cclr1;
  logic [7:0]  out1;
  logic        val1, conf1;
  logic [1:0]  sel1;
  logic [1:0]  cnt1;
  logic [1:0]  st1;

  param_bus_reg u_big (
    .clock(clk), .clear(clear),
    .src_en(en0), .src_data(dat0),
    .hold_en(hold0), .cnt_clr(cclr0),
    .bus_out(out0), .bus_valid(val0),
    .bus_sel(sel0), .conflict(conf0),
    .conflict_cnt(cnt0), .state(st0)
  );

  param_bus_reg #(
    .WIDTH(8), .N_SRC(3), .CNT_W(2),
    .IDLE_VAL(8'h5A)
  ) u_small (
    .clock(clk), .clear(clear),
    .src_en(en1), .src_data(dat1),
    .hold_en(hold1), .cnt_clr(cclr1),
    .bus_out(out1), .bus_valid(val1),
    .bus_sel(sel1), .conflict(conf1),
    .conflict_cnt(cnt1), .state(st1)
  );

  int vec = 0;
  int miss = 0;
  exp_t q0[$];
  exp_t q1[$];

  function automatic exp_t E(logic [31:0] o, logic v,
      logic [4:0] s, logic c, logic [7:0] n, logic [1:0] t);
    exp_t e;
    e.out = o; e.valid = v; e.sel = s;
    e.conf = c; e.cnt = n; e.st = t;
    return e;
  endfunction

  function automatic logic [31:0] bg(int i);
    return 32'h1000_0000 + 32'(i) * 32'h0011_0001;
  endfunction

  task automatic chk(string nm, exp_t a, exp_t e);
    vec++;
    if (a.out !== e.out || a.valid !== e.valid ||
        a.sel !== e.sel || a.conf !== e.conf ||
        a.cnt !== e.cnt || a.st !== e.st) begin
      miss++;
      $display("FAIL %s: got out=%h v=%b sel=%0d c=%b n=%0d st=%b want out=%h v=%b sel=%0d c=%b n=%0d st=%b",
        nm, a.out, a.valid, a.sel, a.conf, a.cnt, a.st,
        e.out, e.valid, e.sel, e.conf, e.cnt, e.st);
    end
  endtask

  function automatic exp_t act0();
    return E(out0, val0, sel0, conf0, cnt0, st0);
  endfunction

  function automatic exp_t act1();
    return E({24'h0, out1}, val1, {3'b0, sel1}, conf1,
             {6'b0, cnt1}, st1);
  endfunction

  // monitor: one registered result per edge after each issued vector
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) chk("big", act0(), q0.pop_front());
    if (q1.size() > 0) chk("small", act1(), q1.pop_front());
  end

  task automatic step0(logic [23:0] en, logic h,
                       logic cc, exp_t e);
    @(negedge clk);
    en0 = en; hold0 = h; cclr0 = cc;
    q0.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic step1(logic [2:0] en, logic h,
                       logic cc, exp_t e);
    @(negedge clk);
    en1 = en; hold1 = h; cclr1 = cc;
    q1.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    clear = 1'b1;
    en0 = '0; hold0 = 0; cclr0 = 0;
    en1 = '0; hold1 = 0; cclr1 = 0;
    for (int i = 0; i < 24; i++) dat0[i*32 +: 32] = bg(i);
    dat1 = {8'h33, 8'h22, 8'h11};
    #12;
    chk("reset_big", act0(), E(0, 0, 0, 0, 0, 0));
    chk("reset_small", act1(), E(32'h5A, 0, 0, 0, 0, 0));
    @(negedge clk);
    clear = 1'b0;

    step0(0, 0, 0, E(0, 0, 0, 0, 0, 2'b00));
    dat0[3*32 +: 32] = 32'hDEADBEEF;
    step0(24'h8, 0, 0, E(32'hDEADBEEF, 1, 3, 0, 0, 2'b01));
    dat0[3*32 +: 32] = 32'hCAFEF00D;
    step0(24'h8, 0, 0, E(32'hCAFEF00D, 1, 3, 0, 0, 2'b01));
    step0(24'h84, 0, 0, E(bg(2), 1, 2, 1, 1, 2'b01));
    step0(24'h80, 0, 0, E(bg(7), 1, 7, 0, 1, 2'b01));
    dat0[4*32 +: 32] = 32'h12345678;
    step0(24'h10, 0, 0, E(32'h12345678, 1, 4, 0, 1, 2'b01));
    for (int k = 0; k < 3; k++)
      step0(0, 1, 0, E(32'h12345678, 0, 4, 0, 1, 2'b10));
    step0(0, 0, 0, E(0, 0, 0, 0, 1, 2'b00));
    step0(0, 1, 0, E(0, 0, 0, 0, 1, 2'b00));
    step0(24'h800000, 0, 0, E(bg(23), 1, 23, 0, 1, 2'b01));
    step0(24'hFFFFFF, 0, 0, E(bg(0), 1, 0, 1, 2, 2'b01));
    step0(24'hFFFFFF, 0, 1, E(bg(0), 1, 0, 1, 0, 2'b01));
    step0(24'hC00000, 1, 0, E(bg(22), 1, 22, 1, 1, 2'b01));
    step0(0, 1, 0, E(bg(22), 0, 22, 0, 1, 2'b10));
    step0(24'h1, 1, 0, E(bg(0), 1, 0, 0, 1, 2'b01));
    step0(24'h20, 0, 0, E(bg(5), 1, 5, 0, 1, 2'b01));

    // asynchronous clear in the middle of a cycle, source 5 still on
    clear = 1'b1;
    #1;
    chk("async_clear", act0(), E(0, 0, 0, 0, 0, 2'b00));
    en0 = '0;
    @(negedge clk);
    clear = 1'b0;
    step0(0, 1, 0, E(0, 0, 0, 0, 0, 2'b00));

    // 8-bit counter saturates at 255 and does not wrap
    for (int k = 1; k <= 257; k++)
      step0(24'h3, 0, 0,
            E(bg(0), 1, 0, 1, (k < 255) ? 8'(k) : 8'hFF, 2'b01));
    step0(0, 0, 1, E(0, 0, 0, 0, 0, 2'b00));

    // small build: 2-bit counter, idle value 0x5A
    step1(3'b000, 0, 0, E(32'h5A, 0, 0, 0, 0, 2'b00));
    step1(3'b110, 0, 0, E(32'h22, 1, 1, 1, 1, 2'b01));
    step1(3'b110, 0, 0, E(32'h22, 1, 1, 1, 2, 2'b01));
    step1(3'b110, 0, 0, E(32'h22, 1, 1, 1, 3, 2'b01));
    step1(3'b110, 0, 0, E(32'h22, 1, 1, 1, 3, 2'b01));
    step1(3'b110, 0, 0, E(32'h22, 1, 1, 1, 3, 2'b01));
    step1(3'b101, 0, 1, E(32'h11, 1, 0, 1, 0, 2'b01));
    step1(3'b100, 0, 0, E(32'h33, 1, 2, 0, 0, 2'b01));
    step1(3'b000, 1, 0, E(32'h33, 0, 2, 0, 0, 2'b10));
    step1(3'b000, 0, 0, E(32'h5A, 0, 0, 0, 0, 2'b00));
    step1(3'b111, 0, 0, E(32'h11, 1, 0, 1, 1, 2'b01));

    repeat (2) @(posedge clk);
    #3;
    vec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miss++;
      $display("FAIL drain: got %0d/%0d pending want 0/0",
               q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
